// File: rtl/alu_program_sequencer.sv
// ---------------------------------------------------------------------------
// alu_program_sequencer
//
// Purpose:
//   Micro-sequencer that sits in front of cpu_top. It runs a short program of
//   ALU micro-instructions held in a synchronous program ROM. Each instruction
//   takes four cycles (FETCH, LOAD, EXEC, WB): it reads two register operands,
//   drives the 74181-based ALU, latches the result and carry, and optionally
//   writes the result back. While idle, the host port is passed straight
//   through to the register file, so the host and the sequencer share it.
//
// Instruction word, LSB upward:
//   imm[DATA_WIDTH-1:0], srcB, srcA, dst (ADDR_WIDTH each),
//   comm[3:0], mode, cin, b_sel, wb_en, halt (MSB)
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   start, abort          run control; start only honoured while idle
//   busy, done, overrun   status; done is a one-cycle pulse, overrun is sticky
//   imem_addr/rd_en/rdata program ROM interface (data valid one cycle later)
//   host_reg_*            host register-file access, active only while idle
//   host_busy_err         pulse when a host write is dropped while busy
//   dp_*                  register-file and ALU controls towards cpu_top
//   dp_alu_result/cout    ALU outputs from cpu_top
//   last_result, flag_*   result, carry and zero of the last executed instr
// ---------------------------------------------------------------------------
module alu_program_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_REGS    = 8,
    parameter int PROG_DEPTH  = 32,
    parameter int ADDR_WIDTH  = $clog2(NUM_REGS),
    parameter int PC_WIDTH    = $clog2(PROG_DEPTH),
    parameter int INSTR_WIDTH = DATA_WIDTH + 3*ADDR_WIDTH + 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic                   imem_rd_en,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   host_reg_we,
    input  logic [ADDR_WIDTH-1:0]  host_reg_waddr,
    input  logic [DATA_WIDTH-1:0]  host_reg_wdata,
    input  logic [ADDR_WIDTH-1:0]  host_rd_addr1,
    input  logic [ADDR_WIDTH-1:0]  host_rd_addr2,
    output logic                   host_busy_err,
    output logic                   dp_reg_write_enable,
    output logic [ADDR_WIDTH-1:0]  dp_reg_write_addr,
    output logic [DATA_WIDTH-1:0]  dp_reg_write_data,
    output logic [ADDR_WIDTH-1:0]  dp_reg_read_addr1,
    output logic [ADDR_WIDTH-1:0]  dp_reg_read_addr2,
    output logic [3:0]             dp_alu_comm,
    output logic                   dp_alu_mode,
    output logic                   dp_alu_cin,
    output logic                   dp_b_source_sel,
    output logic [DATA_WIDTH-1:0]  dp_alu_b_imm,
    input  logic [DATA_WIDTH-1:0]  dp_alu_result,
    input  logic                   dp_alu_cout,
    output logic [DATA_WIDTH-1:0]  last_result,
    output logic                   flag_cout,
    output logic                   flag_zero
);

    // Bit positions of the instruction fields
    localparam int SRCB_LSB = DATA_WIDTH;
    localparam int SRCA_LSB = DATA_WIDTH + ADDR_WIDTH;
    localparam int DST_LSB  = DATA_WIDTH + 2*ADDR_WIDTH;
    localparam int COMM_LSB = DATA_WIDTH + 3*ADDR_WIDTH;
    localparam int MODE_BIT = COMM_LSB + 4;
    localparam int CIN_BIT  = COMM_LSB + 5;
    localparam int BSEL_BIT = COMM_LSB + 6;
    localparam int WBEN_BIT = COMM_LSB + 7;
    localparam int HALT_BIT = COMM_LSB + 8;

    localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(PROG_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        EXEC,
        WB
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [PC_WIDTH-1:0]      r_pc;
    logic [INSTR_WIDTH-1:0]   r_ir;
    logic [DATA_WIDTH-1:0]    r_last_result;
    logic                     r_flag_cout;
    logic                     r_flag_zero;
    logic                     r_overrun;
    logic                     r_done;
    logic                     r_host_busy_err;

    logic                     w_start_run;
    logic                     w_load_ir;
    logic                     w_latch_exec;
    logic                     w_pc_inc;
    logic                     w_set_overrun;
    logic                     w_done_next;

    logic [DATA_WIDTH-1:0]    w_imm;
    logic [ADDR_WIDTH-1:0]    w_src_b;
    logic [ADDR_WIDTH-1:0]    w_src_a;
    logic [ADDR_WIDTH-1:0]    w_dst;
    logic [3:0]               w_comm;
    logic                     w_mode;
    logic                     w_cin;
    logic                     w_b_sel;
    logic                     w_wb_en;
    logic                     w_halt;

    // Field decode of the instruction register
    assign w_imm   = r_ir[DATA_WIDTH-1:0];
    assign w_src_b = r_ir[SRCB_LSB +: ADDR_WIDTH];
    assign w_src_a = r_ir[SRCA_LSB +: ADDR_WIDTH];
    assign w_dst   = r_ir[DST_LSB +: ADDR_WIDTH];
    assign w_comm  = r_ir[COMM_LSB +: 4];
    assign w_mode  = r_ir[MODE_BIT];
    assign w_cin   = r_ir[CIN_BIT];
    assign w_b_sel = r_ir[BSEL_BIT];
    assign w_wb_en = r_ir[WBEN_BIT];
    assign w_halt  = r_ir[HALT_BIT];

    assign busy          = (r_state != IDLE);
    assign done          = r_done;
    assign overrun       = r_overrun;
    assign host_busy_err = r_host_busy_err;
    assign imem_addr     = r_pc;
    assign last_result   = r_last_result;
    assign flag_cout     = r_flag_cout;
    assign flag_zero     = r_flag_zero;

    // State register and all datapath registers of the sequencer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_pc            <= '0;
            r_ir            <= '0;
            r_last_result   <= '0;
            r_flag_cout     <= 1'b0;
            r_flag_zero     <= 1'b0;
            r_overrun       <= 1'b0;
            r_done          <= 1'b0;
            r_host_busy_err <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_done          <= w_done_next;
            // Any host write attempted outside IDLE is dropped and flagged
            r_host_busy_err <= host_reg_we && (r_state != IDLE);
            if (w_start_run) begin
                r_pc <= '0;
            end else if (w_pc_inc) begin
                r_pc <= r_pc + PC_WIDTH'(1);
            end
            if (w_load_ir) begin
                r_ir <= imem_rdata;
            end
            if (w_latch_exec) begin
                r_last_result <= dp_alu_result;
                r_flag_cout   <= dp_alu_cout;
                r_flag_zero   <= (dp_alu_result == '0);
            end
            if (w_start_run) begin
                r_overrun <= 1'b0;
            end else if (w_set_overrun) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Next-state logic; abort in any busy state overrides every other move
    // and cancels the side effects of the current cycle.
    always_comb begin
        w_next_state  = r_state;
        w_start_run   = 1'b0;
        w_load_ir     = 1'b0;
        w_latch_exec  = 1'b0;
        w_pc_inc      = 1'b0;
        w_set_overrun = 1'b0;
        w_done_next   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_next_state = FETCH;
                    w_start_run  = 1'b1;
                end
            end
            FETCH: begin
                w_next_state = LOAD;
            end
            LOAD: begin
                w_next_state = EXEC;
                w_load_ir    = 1'b1;
            end
            EXEC: begin
                w_next_state = WB;
                w_latch_exec = 1'b1;
            end
            WB: begin
                if (w_halt) begin
                    w_next_state = IDLE;
                    w_done_next  = 1'b1;
                end else if (r_pc == LAST_PC) begin
                    w_next_state  = IDLE;
                    w_done_next   = 1'b1;
                    w_set_overrun = 1'b1;
                end else begin
                    w_next_state = FETCH;
                    w_pc_inc     = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        if (abort && (r_state != IDLE)) begin
            w_next_state  = IDLE;
            w_done_next   = 1'b1;
            w_load_ir     = 1'b0;
            w_latch_exec  = 1'b0;
            w_pc_inc      = 1'b0;
            w_set_overrun = 1'b0;
        end
    end

    // Datapath outputs: host pass-through in IDLE, decoded IR in EXEC/WB.
    // WB writes back the value latched at the end of EXEC.
    always_comb begin
        imem_rd_en          = 1'b0;
        dp_reg_write_enable = 1'b0;
        dp_reg_write_addr   = '0;
        dp_reg_write_data   = '0;
        dp_reg_read_addr1   = '0;
        dp_reg_read_addr2   = '0;
        dp_alu_comm         = 4'b0000;
        dp_alu_mode         = 1'b0;
        dp_alu_cin          = 1'b0;
        dp_b_source_sel     = 1'b0;
        dp_alu_b_imm        = '0;
        case (r_state)
            IDLE: begin
                dp_reg_write_enable = host_reg_we;
                dp_reg_write_addr   = host_reg_waddr;
                dp_reg_write_data   = host_reg_wdata;
                dp_reg_read_addr1   = host_rd_addr1;
                dp_reg_read_addr2   = host_rd_addr2;
            end
            FETCH: begin
                imem_rd_en = 1'b1;
            end
            EXEC, WB: begin
                dp_reg_read_addr1 = w_src_a;
                dp_reg_read_addr2 = w_src_b;
                dp_alu_comm       = w_comm;
                dp_alu_mode       = w_mode;
                dp_alu_cin        = w_cin;
                dp_b_source_sel   = w_b_sel;
                dp_alu_b_imm      = w_imm;
                if (r_state == WB) begin
                    dp_reg_write_enable = w_wb_en && !abort;
                    dp_reg_write_addr   = w_dst;
                    dp_reg_write_data   = r_last_result;
                end
            end
            default: begin
                imem_rd_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_program_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_program_sequencer
//
// Purpose:
//   Self-checking bench for alu_program_sequencer. It supplies a program ROM,
//   a register file and a simple ALU standing in for cpu_top, and compares
//   the sequencer against a program-level reference model that executes the
//   ROM contents instruction by instruction.
// ---------------------------------------------------------------------------
module tb_alu_program_sequencer;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int PD = 32;
    localparam int PW = 5;
    localparam int IW = 34;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          overrun;
    logic [PW-1:0] imem_addr;
    logic          imem_rd_en;
    logic [IW-1:0] imem_rdata;
    logic          host_reg_we;
    logic [AW-1:0] host_reg_waddr;
    logic [DW-1:0] host_reg_wdata;
    logic [AW-1:0] host_rd_addr1;
    logic [AW-1:0] host_rd_addr2;
    logic          host_busy_err;
    logic          dp_reg_write_enable;
    logic [AW-1:0] dp_reg_write_addr;
    logic [DW-1:0] dp_reg_write_data;
    logic [AW-1:0] dp_reg_read_addr1;
    logic [AW-1:0] dp_reg_read_addr2;
    logic [3:0]    dp_alu_comm;
    logic          dp_alu_mode;
    logic          dp_alu_cin;
    logic          dp_b_source_sel;
    logic [DW-1:0] dp_alu_b_imm;
    logic [DW-1:0] dp_alu_result;
    logic          dp_alu_cout;
    logic [DW-1:0] last_result;
    logic          flag_cout;
    logic          flag_zero;

    logic [IW-1:0] rom [PD];
    logic [DW-1:0] regs [8];
    logic [DW-1:0] mRegs [8];
    logic [DW-1:0] mLast;
    logic          mCout;
    logic          mZero;
    logic [16:0]   aluOut;

    int assertCount;
    int failCount;

    alu_program_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .abort               (abort),
        .busy                (busy),
        .done                (done),
        .overrun             (overrun),
        .imem_addr           (imem_addr),
        .imem_rd_en          (imem_rd_en),
        .imem_rdata          (imem_rdata),
        .host_reg_we         (host_reg_we),
        .host_reg_waddr      (host_reg_waddr),
        .host_reg_wdata      (host_reg_wdata),
        .host_rd_addr1       (host_rd_addr1),
        .host_rd_addr2       (host_rd_addr2),
        .host_busy_err       (host_busy_err),
        .dp_reg_write_enable (dp_reg_write_enable),
        .dp_reg_write_addr   (dp_reg_write_addr),
        .dp_reg_write_data   (dp_reg_write_data),
        .dp_reg_read_addr1   (dp_reg_read_addr1),
        .dp_reg_read_addr2   (dp_reg_read_addr2),
        .dp_alu_comm         (dp_alu_comm),
        .dp_alu_mode         (dp_alu_mode),
        .dp_alu_cin          (dp_alu_cin),
        .dp_b_source_sel     (dp_b_source_sel),
        .dp_alu_b_imm        (dp_alu_b_imm),
        .dp_alu_result       (dp_alu_result),
        .dp_alu_cout         (dp_alu_cout),
        .last_result         (last_result),
        .flag_cout           (flag_cout),
        .flag_zero           (flag_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Subset of 74181 behaviour used by the programs: {cout, result}
    function automatic logic [16:0] aluModel(input logic [3:0] comm, input logic mode,
                                             input logic cin, input logic [15:0] a,
                                             input logic [15:0] b);
        logic [16:0] r;
        if (mode) begin
            case (comm)
                4'b0000: r = {1'b0, ~a};
                4'b0110: r = {1'b0, a ^ b};
                4'b1011: r = {1'b0, a & b};
                4'b1110: r = {1'b0, a | b};
                default: r = {1'b0, a};
            endcase
        end else begin
            case (comm)
                4'b1001: r = {1'b0, a} + {1'b0, b} + 17'(cin);
                4'b1100: r = {1'b0, a} + {1'b0, a} + 17'(cin);
                4'b0110: r = {1'b0, a} + {1'b0, ~b} + 17'(cin);
                default: r = {1'b0, a} + 17'(cin);
            endcase
        end
        return r;
    endfunction

    // cpu_top stand-in: combinational ALU, register file written on the edge,
    // synchronous ROM with one cycle of read latency
    always_comb begin
        aluOut = aluModel(dp_alu_comm, dp_alu_mode, dp_alu_cin, regs[dp_reg_read_addr1],
                          dp_b_source_sel ? dp_alu_b_imm : regs[dp_reg_read_addr2]);
    end
    assign dp_alu_result = aluOut[15:0];
    assign dp_alu_cout   = aluOut[16];

    always @(posedge clk) begin
        if (dp_reg_write_enable) regs[dp_reg_write_addr] <= dp_reg_write_data;
        if (imem_rd_en) imem_rdata <= rom[imem_addr];
    end

    function automatic logic [IW-1:0] mkInstr(input logic halt, input logic wb, input logic bsel,
                                              input logic cin, input logic mode,
                                              input logic [3:0] comm, input logic [2:0] dst,
                                              input logic [2:0] srcA, input logic [2:0] srcB,
                                              input logic [15:0] imm);
        return {halt, wb, bsel, cin, mode, comm, dst, srcA, srcB, imm};
    endfunction

    function automatic logic [IW-1:0] randInstr(input logic halt);
        logic [3:0] c;
        case ($urandom_range(0, 3))
            0:       c = 4'b1001;
            1:       c = 4'b1100;
            2:       c = 4'b0110;
            default: c = 4'b1011;
        endcase
        return mkInstr(halt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c,
                       3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)), 16'($urandom));
    endfunction

    task automatic clearRom();
        for (int i = 0; i < PD; i++) rom[i] = '0;
    endtask

    // Program-level reference: walk the ROM from address 0 until a halt or
    // the end of the ROM, updating the model register file
    task automatic modelRun(output int nInstr, output logic ovr);
        logic [IW-1:0] w;
        logic [15:0]   a;
        logic [15:0]   b;
        logic [16:0]   r;
        logic          halted;
        nInstr = 0;
        halted = 1'b0;
        for (int pc = 0; pc < PD; pc++) begin
            w = rom[pc];
            a = mRegs[w[21:19]];
            b = w[31] ? w[15:0] : mRegs[w[18:16]];
            r = aluModel(w[28:25], w[29], w[30], a, b);
            mLast = r[15:0];
            mCout = r[16];
            mZero = (r[15:0] == 16'h0000);
            if (w[32]) mRegs[w[24:22]] = r[15:0];
            nInstr++;
            if (w[33]) begin
                halted = 1'b1;
                break;
            end
        end
        ovr = !halted;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic hostWrite(input logic [2:0] addr, input logic [15:0] data);
        logic [2:0] naddr;
        naddr          = ~addr;
        host_reg_we    = 1'b1;
        host_reg_waddr = addr;
        host_reg_wdata = data;
        host_rd_addr1  = addr;
        host_rd_addr2  = naddr;
        #1;
        checkOutput("idle_we_mirror", dp_reg_write_enable, 1);
        checkOutput("idle_waddr_mirror", dp_reg_write_addr, addr);
        checkOutput("idle_wdata_mirror", dp_reg_write_data, data);
        checkOutput("idle_raddr1_mirror", dp_reg_read_addr1, addr);
        checkOutput("idle_raddr2_mirror", dp_reg_read_addr2, naddr);
        checkOutput("idle_alu_comm_zero", dp_alu_comm, 0);
        @(negedge clk);
        host_reg_we = 1'b0;
        mRegs[addr] = data;
    endtask

    // Start the program at a negedge and follow it to the end. Optional
    // actions are keyed to the busy-cycle number (0 = not used).
    task automatic applyStimulus(input int abortAt, input int hostAt, input logic [2:0] hAddr,
                                 input logic [15:0] hData, input int resetAt,
                                 output int busyCycles);
        int   guard;
        logic hostPending;
        logic resetHit;
        hostPending = 1'b0;
        resetHit    = 1'b0;
        busyCycles  = 0;
        guard       = 0;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (busy === 1'b1 && guard < 4*PD + 16) begin
            guard++;
            busyCycles++;
            host_reg_we = 1'b0;
            checkOutput("done_low_while_busy", done, 0);
            if (hostPending) begin
                checkOutput("host_busy_err_pulse", host_busy_err, 1);
                hostPending = 1'b0;
            end
            if (busyCycles == hostAt) begin
                host_reg_we    = 1'b1;
                host_reg_waddr = hAddr;
                host_reg_wdata = hData;
                #1;
                checkOutput("host_we_dropped", dp_reg_write_enable, 0);
                hostPending = 1'b1;
            end
            if (busyCycles == abortAt) begin
                abort = 1'b1;
                #1;
                checkOutput("abort_wb_no_write", dp_reg_write_enable, 0);
            end
            if (busyCycles == resetAt) begin
                reset = 1'b0;
                #1;
                checkOutput("reset_busy", busy, 0);
                checkOutput("reset_last_result", last_result, 0);
                checkOutput("reset_flag_cout", flag_cout, 0);
                checkOutput("reset_flag_zero", flag_zero, 0);
                checkOutput("reset_done", done, 0);
                checkOutput("reset_overrun", overrun, 0);
                resetHit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        host_reg_we = 1'b0;
        abort       = 1'b0;
        if (resetHit) begin
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
        end else begin
            if (busy !== 1'b0) checkOutput("busy_timeout", busy, 0);
            if (hostPending) checkOutput("host_busy_err_pulse", host_busy_err, 1);
            checkOutput("done_pulse", done, 1);
            @(negedge clk);
            checkOutput("done_one_cycle", done, 0);
            checkOutput("host_busy_err_cleared", host_busy_err, 0);
        end
    endtask

    task automatic checkModel(input string tag, input int nInstr, input logic expOvr,
                              input int cyc);
        for (int i = 0; i < 8; i++) checkOutput({tag, "_reg"}, regs[i], mRegs[i]);
        checkOutput({tag, "_last_result"}, last_result, mLast);
        checkOutput({tag, "_flag_cout"}, flag_cout, mCout);
        checkOutput({tag, "_flag_zero"}, flag_zero, mZero);
        checkOutput({tag, "_overrun"}, overrun, expOvr);
        checkOutput({tag, "_cycles"}, cyc, 4*nInstr);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int          cyc;
        int          nI;
        int          len;
        logic        ovr;
        logic [16:0] expR;

        assertCount    = 0;
        failCount      = 0;
        reset          = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        host_reg_we    = 1'b0;
        host_reg_waddr = '0;
        host_reg_wdata = '0;
        host_rd_addr1  = '0;
        host_rd_addr2  = '0;
        clearRom();
        for (int i = 0; i < 8; i++) mRegs[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_last_result", last_result, 0);
        checkOutput("rst_flag_cout", flag_cout, 0);
        checkOutput("rst_flag_zero", flag_zero, 0);
        checkOutput("rst_host_busy_err", host_busy_err, 0);
        checkOutput("rst_imem_rd_en", imem_rd_en, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) hostWrite(3'(i), 16'h0000);

        // start together with abort in IDLE: nothing happens
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start_abort_busy", busy, 0);
        checkOutput("start_abort_done", done, 0);

        // Single add: r4 = r2 + r3
        $display("[TB] single-instruction add");
        hostWrite(3'd2, 16'h1234);
        hostWrite(3'd3, 16'h5678);
        clearRom();
        rom[0] = mkInstr(1, 1, 0, 0, 0, 4'b1001, 3'd4, 3'd2, 3'd3, 16'h0000);
        modelRun(nI, ovr);
        applyStimulus(0, 0, 3'd0, 16'h0, 0, cyc);
        checkOutput("t1_cycles", cyc, 4);
        checkOutput("t1_r4", regs[4], 16'h68AC);
        checkOutput("t1_flag_cout", flag_cout, 0);
        checkOutput("t1_flag_zero", flag_zero, 0);
        checkModel("t1", nI, ovr, cyc);

        // Immediate add wrapping to zero: r5 = FFFF + 1
        $display("[TB] immediate add with carry out");
        hostWrite(3'd5, 16'hFFFF);
        clearRom();
        rom[0] = mkInstr(1, 1, 1, 0, 0, 4'b1001, 3'd5, 3'd5, 3'd0, 16'h0001);
        modelRun(nI, ovr);
        applyStimulus(0, 0, 3'd0, 16'h0, 0, cyc);
        checkOutput("t2_r5", regs[5], 16'h0000);
        checkOutput("t2_last_result", last_result, 16'h0000);
        checkOutput("t2_flag_cout", flag_cout, 1);
        checkOutput("t2_flag_zero", flag_zero, 1);
        checkModel("t2", nI, ovr, cyc);

        // Two instructions, host write to r7 attempted mid-run
        $display("[TB] two-instruction program with blocked host write");
        hostWrite(3'd0, 16'h0005);
        hostWrite(3'd1, 16'h0003);
        clearRom();
        rom[0] = mkInstr(0, 1, 0, 0, 0, 4'b1001, 3'd6, 3'd0, 3'd1, 16'h0000);
        rom[1] = mkInstr(1, 1, 0, 0, 0, 4'b1100, 3'd6, 3'd6, 3'd0, 16'h0000);
        modelRun(nI, ovr);
        applyStimulus(0, 2, 3'd7, 16'hDEAD, 0, cyc);
        checkOutput("t3_cycles", cyc, 8);
        checkOutput("t3_r6", regs[6], 16'h0010);
        checkOutput("t3_r7_untouched", regs[7], mRegs[7]);
        checkModel("t3", nI, ovr, cyc);

        // Abort in the WB cycle of a write-back instruction
        $display("[TB] abort during write-back");
        clearRom();
        rom[0] = mkInstr(1, 1, 0, 0, 0, 4'b1001, 3'd1, 3'd2, 3'd3, 16'h0000);
        expR = aluModel(4'b1001, 1'b0, 1'b0, mRegs[2], mRegs[3]);
        applyStimulus(4, 0, 3'd0, 16'h0, 0, cyc);
        checkOutput("abort_cycles", cyc, 4);
        checkOutput("abort_r1_unchanged", regs[1], mRegs[1]);
        checkOutput("abort_last_result", last_result, expR[15:0]);

        // No halt anywhere: run past the end of the ROM
        $display("[TB] overrun");
        for (int i = 0; i < PD; i++) rom[i] = randInstr(1'b0);
        modelRun(nI, ovr);
        applyStimulus(0, 0, 3'd0, 16'h0, 0, cyc);
        checkOutput("ovr_cycles", cyc, 4*PD);
        checkOutput("ovr_flag", overrun, 1);
        checkModel("ovr", nI, ovr, cyc);
        clearRom();
        rom[0] = mkInstr(1, 0, 1, 0, 1, 4'b1111, 3'd0, 3'd2, 3'd0, 16'h0000);
        modelRun(nI, ovr);
        applyStimulus(0, 0, 3'd0, 16'h0, 0, cyc);
        checkOutput("ovr_cleared", overrun, 0);
        checkModel("ovr_next", nI, ovr, cyc);

        // Reset during EXEC of the second instruction, then rerun from PC 0
        $display("[TB] asynchronous reset mid-program");
        hostWrite(3'd4, 16'hFFFF);
        clearRom();
        rom[0] = mkInstr(0, 1, 1, 0, 0, 4'b1001, 3'd7, 3'd4, 3'd0, 16'h0002);
        rom[1] = mkInstr(1, 1, 0, 0, 0, 4'b1100, 3'd6, 3'd4, 3'd0, 16'h0000);
        modelRun(nI, ovr);
        applyStimulus(0, 0, 3'd0, 16'h0, 0, cyc);
        checkModel("pre_reset", nI, ovr, cyc);
        applyStimulus(0, 0, 3'd0, 16'h0, 7, cyc);
        modelRun(nI, ovr);
        applyStimulus(0, 0, 3'd0, 16'h0, 0, cyc);
        checkOutput("post_reset_last", last_result, 16'hFFFE);
        checkModel("post_reset", nI, ovr, cyc);

        // Random programs against the reference model
        $display("[TB] random programs");
        for (int t = 0; t < 6; t++) begin
            hostWrite(3'($urandom_range(0, 7)), 16'($urandom));
            hostWrite(3'($urandom_range(0, 7)), 16'($urandom));
            clearRom();
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) rom[i] = randInstr(i == len - 1);
            modelRun(nI, ovr);
            applyStimulus(0, 0, 3'd0, 16'h0, 0, cyc);
            checkModel("rand", nI, ovr, cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_program_sequencer.md
Name: alu_program_sequencer

Overview:
Micro-sequencer that sits in front of cpu_top and runs a short program of ALU micro-instructions from a synchronous program ROM. Each instruction reads register operands, drives the 74181-based ALU, latches the result and carry, and optionally writes the result back to the register file. When the sequencer is idle, it passes a host port through to the register file, so the host and the sequencer share the register file.

Parameters:
DATA_WIDTH, 16, datapath and immediate width
NUM_REGS, 8, register file depth; ADDR_WIDTH = $clog2(NUM_REGS)
PROG_DEPTH, 32, program ROM depth; PC_WIDTH = $clog2(PROG_DEPTH)
INSTR_WIDTH, DATA_WIDTH+3*ADDR_WIDTH+9, instruction word width (34 at defaults)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  start the program at PC 0; honored only in IDLE
abort  in  1  synchronous abort; return to IDLE
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when a program ends (halt, overrun or abort)
overrun  out  1  sticky; set when the PC runs past PROG_DEPTH-1 without a halt; cleared on start
imem_addr  out  PC_WIDTH  program ROM address
imem_rd_en  out  1  ROM read strobe
imem_rdata  in  INSTR_WIDTH  ROM data, valid the cycle after imem_rd_en
host_reg_we, host_reg_waddr, host_reg_wdata  in  1/ADDR_WIDTH/DATA_WIDTH  host register write
host_rd_addr1, host_rd_addr2  in  ADDR_WIDTH  host read addresses
host_busy_err  out  1  one-cycle pulse when a host write is dropped because the sequencer is busy
dp_reg_write_enable, dp_reg_write_addr, dp_reg_write_data  out  1/ADDR_WIDTH/DATA_WIDTH  to cpu_top
dp_reg_read_addr1, dp_reg_read_addr2  out  ADDR_WIDTH  to cpu_top
dp_alu_comm  out  4;  dp_alu_mode, dp_alu_cin, dp_b_source_sel  out  1;  dp_alu_b_imm  out  DATA_WIDTH
dp_alu_result  in  DATA_WIDTH;  dp_alu_cout  in  1  from cpu_top
last_result  out  DATA_WIDTH  result of the last executed instruction
flag_cout, flag_zero  out  1  carry-out and (result==0) of the last executed instruction

Behaviour:
- Instruction layout, LSB upward:
  - imm[DATA_WIDTH-1:0], srcB, srcA, dst (ADDR_WIDTH each)
  - comm[3:0], mode, cin, b_sel, wb_en, halt (MSB)
- Reset (reset=0), asynchronous:
  - state=IDLE, PC=0, IR=0.
  - last_result, flag_cout, flag_zero, overrun, done and host_busy_err all cleared to 0.
- FSM states: IDLE, FETCH, LOAD, EXEC, WB. A non-aborted instruction takes exactly 4 cycles.
- IDLE:
  - dp_reg_* mirror the host ports combinationally; ALU controls are 0.
  - start=1 → PC=0, overrun cleared, go to FETCH.
- FETCH: imem_addr=PC, imem_rd_en=1 → LOAD.
- LOAD: IR <= imem_rdata → EXEC.
- EXEC:
  - dp_reg_read_addr1=srcA, dp_reg_read_addr2=srcB; ALU controls and dp_alu_b_imm driven from IR.
  - At the edge: last_result <= dp_alu_result, flag_cout <= dp_alu_cout, flag_zero <= (dp_alu_result==0) → WB.
- WB:
  - dp_reg_write_enable = wb_en & ~abort; dp_reg_write_addr=dst; dp_reg_write_data=last_result.
  - Read addresses and ALU controls are held from EXEC.
  - Then: halt=1 → IDLE with done pulse. Else if PC==PROG_DEPTH-1 → IDLE, overrun=1, done pulse. Else PC+1 → FETCH.
- Outside IDLE: host_reg_we is dropped and host_busy_err pulses the next cycle; host read addresses are ignored.
- abort=1 in any busy state → IDLE at the next edge with a done pulse.
  - In EXEC the flags are not updated; in WB the write is suppressed.
  - PC is left as-is; the next start reloads it to 0.
- start while busy is ignored. start and abort together in IDLE: abort wins, state stays IDLE, no done pulse.
- Reset mid-program aborts immediately. No write is committed after reset asserts; register contents are cpu_top's responsibility.
- done and host_busy_err are registered one-cycle pulses.

Test Plan:
- Host writes r2=1234, r3=5678; ROM[0]: comm=1001, mode=0, cin=0, b_sel=0, srcA=2, srcB=3, dst=4, wb_en=1, halt=1; start → busy for 4 cycles, done pulse, r4=68AC, flag_cout=0, flag_zero=0.
- r5=FFFF; ROM[0]: comm=1001, b_sel=1, imm=0001, srcA=5, dst=5, wb_en=1, halt=1 → r5=0000, last_result=0000, flag_cout=1, flag_zero=1.
- Two-instruction program, ROM[0] computes r6=5+3 into r6, ROM[1]=A+A on r6 with dst=6 and halt → r6=0010, done after 8 cycles; host write during the run → host_busy_err pulse, target register unchanged.
- ROM filled with PROG_DEPTH instructions none having halt → after 4*PROG_DEPTH cycles: overrun=1, done pulse, busy=0; the next start clears overrun.
- abort asserted in the WB cycle of a wb_en=1 instruction → no dp_reg_write_enable, IDLE on the next cycle, done pulse.
- Drive reset=0 asynchronously mid-EXEC → busy=0, all flags 0 and last_result=0 immediately; start after release runs the program from PC 0.
